axil_cmd_master: RTL

- AXI4-Lite initiator. Converts a simple command stream (read/write, address, data) into single AXI4-Lite transactions on a control bus.
- Returns read data and response code on a result stream.
- Drives the team's register-mapped control slaves from hardware sequencers and self-test logic without a MicroBlaze in the loop.
- One transaction is outstanding at a time. No bursts. No write strobes: full 32-bit words only.

---
 rtl/axil_cmd_master.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axil_cmd_master.sv
// axil_cmd_master: turns a simple read/write command stream into single
// AXI4-Lite transactions, one outstanding, and returns the outcome.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_*                 command stream in (valid/ready, write, addr, wdata)
//   rsp_*                 result stream out (valid/ready, rdata, resp,
//                         write echo, timeout flag)
//   m_aw*/m_w*/m_b*       AXI4-Lite write address/data/response channels
//   m_ar*/m_r*            AXI4-Lite read address/data channels
//
// A watchdog counter aborts a transaction after TIMEOUT_CYCLES cycles with
// no handshake progress (0 disables it); the abort drops valids before
// ready, which is only meant for recovering from a dead slave.
module axil_cmd_master #(
   parameter int ADDR_W         = 8,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_tvalid,
   output logic              cmd_tready,
   input  logic              cmd_write,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [31:0]       cmd_wdata,
   output logic              rsp_tvalid,
   input  logic              rsp_tready,
   output logic [31:0]       rsp_rdata,
   output logic [1:0]        rsp_resp,
   output logic              rsp_write,
   output logic              rsp_timeout,
   output logic [ADDR_W-1:0] m_awaddr,
   output logic              m_awvalid,
   input  logic              m_awready,
   output logic [31:0]       m_wdata,
   output logic              m_wvalid,
   input  logic              m_wready,
   input  logic [1:0]        m_bresp,
   input  logic              m_bvalid,
   output logic              m_bready,
   output logic [ADDR_W-1:0] m_araddr,
   output logic              m_arvalid,
   input  logic              m_arready,
   input  logic [31:0]       m_rdata,
   input  logic [1:0]        m_rresp,
   input  logic              m_rvalid,
   output logic              m_rready
);

   localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
   localparam int CW    = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WR,
      S_WR_RESP,
      S_RD_ADDR,
      S_RD_DATA,
      S_RSP
   } state_t;

   state_t r_state;
   state_t w_next;

   logic [ADDR_W-1:0] r_awaddr;
   logic [ADDR_W-1:0] r_araddr;
   logic [31:0]       r_wdata;
   logic              r_awvalid;
   logic              r_wvalid;
   logic              r_bready;
   logic              r_arvalid;
   logic              r_rready;
   logic [31:0]       r_rsp_rdata;
   logic [1:0]        r_rsp_resp;
   logic              r_rsp_write;
   logic              r_rsp_timeout;
   logic [CW-1:0]     r_cnt;

   logic          w_aw_hs;
   logic          w_w_hs;
   logic          w_b_hs;
   logic          w_ar_hs;
   logic          w_r_hs;
   logic          w_any_hs;
   logic          w_busy;
   logic          w_wr_done;
   logic          w_expire;
   logic          w_in_wr;
   logic [CW-1:0] w_cnt_inc;

   assign w_aw_hs  = r_awvalid & m_awready;
   assign w_w_hs   = r_wvalid & m_wready;
   assign w_b_hs   = r_bready & m_bvalid;
   assign w_ar_hs  = r_arvalid & m_arready;
   assign w_r_hs   = r_rready & m_rvalid;
   assign w_any_hs = w_aw_hs | w_w_hs | w_b_hs | w_ar_hs | w_r_hs;

   assign w_in_wr = (r_state == S_WR) || (r_state == S_WR_RESP);
   assign w_busy  = w_in_wr ||
                    (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);

   // Each write channel is finished once its valid is gone or handshaking
   // now; the two may complete in either order or together.
   assign w_wr_done = (~r_awvalid | m_awready) & (~r_wvalid | m_wready);

   // A handshake on the limit cycle wins over the timeout.
   assign w_cnt_inc = r_cnt + CW'(1);
   assign w_expire  = TO_EN && w_busy && !w_any_hs && (w_cnt_inc == TO_LIM);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if (cmd_tvalid) begin
               w_next = cmd_write ? S_WR : S_RD_ADDR;
            end
         end
         S_WR: begin
            if (w_expire) begin
               w_next = S_RSP;
            end else if (w_wr_done) begin
               w_next = S_WR_RESP;
            end
         end
         S_WR_RESP: begin
            if (w_b_hs || w_expire) begin
               w_next = S_RSP;
            end
         end
         S_RD_ADDR: begin
            if (w_expire) begin
               w_next = S_RSP;
            end else if (w_ar_hs) begin
               w_next = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (w_r_hs || w_expire) begin
               w_next = S_RSP;
            end
         end
         S_RSP: begin
            if (rsp_tready) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Watchdog: cleared outside the transaction states and on any handshake,
   // saturating so it can never wrap back to a small value.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (!w_busy || w_any_hs) begin
         r_cnt <= '0;
      end else if (TO_EN && (r_cnt != TO_LIM)) begin
         r_cnt <= w_cnt_inc;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_awaddr      <= '0;
         r_araddr      <= '0;
         r_wdata       <= '0;
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= '0;
         r_rsp_write   <= 1'b0;
         r_rsp_timeout <= 1'b0;
      end else if (w_expire) begin
         r_awvalid     <= 1'b0;
         r_wvalid      <= 1'b0;
         r_bready      <= 1'b0;
         r_arvalid     <= 1'b0;
         r_rready      <= 1'b0;
         r_rsp_rdata   <= '0;
         r_rsp_resp    <= 2'b10;
         r_rsp_write   <= w_in_wr;
         r_rsp_timeout <= 1'b1;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (cmd_tvalid) begin
                  r_rsp_timeout <= 1'b0;
                  if (cmd_write) begin
                     r_awaddr  <= cmd_addr;
                     r_wdata   <= cmd_wdata;
                     r_awvalid <= 1'b1;
                     r_wvalid  <= 1'b1;
                  end else begin
                     r_araddr  <= cmd_addr;
                     r_arvalid <= 1'b1;
                  end
               end
            end
            S_WR: begin
               if (w_aw_hs) begin
                  r_awvalid <= 1'b0;
               end
               if (w_w_hs) begin
                  r_wvalid <= 1'b0;
               end
               if (w_wr_done) begin
                  r_bready <= 1'b1;
               end
            end
            S_WR_RESP: begin
               if (w_b_hs) begin
                  r_bready    <= 1'b0;
                  r_rsp_resp  <= m_bresp;
                  r_rsp_rdata <= '0;
                  r_rsp_write <= 1'b1;
               end
            end
            S_RD_ADDR: begin
               if (w_ar_hs) begin
                  r_arvalid <= 1'b0;
                  r_rready  <= 1'b1;
               end
            end
            S_RD_DATA: begin
               if (w_r_hs) begin
                  r_rready    <= 1'b0;
                  r_rsp_rdata <= m_rdata;
                  r_rsp_resp  <= m_rresp;
                  r_rsp_write <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign cmd_tready  = (r_state == S_IDLE);
   assign rsp_tvalid  = (r_state == S_RSP);
   assign rsp_rdata   = r_rsp_rdata;
   assign rsp_resp    = r_rsp_resp;
   assign rsp_write   = r_rsp_write;
   assign rsp_timeout = r_rsp_timeout;
   assign m_awaddr    = r_awaddr;
   assign m_awvalid   = r_awvalid;
   assign m_wdata     = r_wdata;
   assign m_wvalid    = r_wvalid;
   assign m_bready    = r_bready;
   assign m_araddr    = r_araddr;
   assign m_arvalid   = r_arvalid;
   assign m_rready    = r_rready;

endmodule
